// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit engine: register map, FSM states
// and STATUS field positions.
package uart_tx_pkg;

  localparam logic [11:0] ADDR_DIV    = 12'h000;
  localparam logic [11:0] ADDR_TXDATA = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h010;
  localparam logic [11:0] ADDR_CLR    = 12'h014;
  localparam logic [11:0] ADDR_LEVEL  = 12'h018;
  localparam logic [11:0] ADDR_TXEN   = 12'h01C;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int STATUS_EMPTY    = 0;
  localparam int STATUS_FULL     = 1;
  localparam int STATUS_BUSY     = 2;
  localparam int STATUS_OVERFLOW = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO for the UART transmitter; rdata is the head entry
// whenever the FIFO is not empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pop is resolved first so a full FIFO can accept a push in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: register block, TX FIFO and 8N1 framing FSM with a
// per-frame sampled baud divisor.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [11:0] reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        tx_o,
  output logic        intr_tx,
  output logic        intr_tx_level,
  output logic        intr_tx_full,
  output logic        intr_tx_empty
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] ctrl_div;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] bit_cnt;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] fifo_count;
  logic             txen;
  logic             overflow;
  tx_state_e        state;
  logic [7:0]       shift_q;
  logic [7:0]       fifo_rdata;
  logic [2:0]       bit_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             start_ok;
  logic             bit_end;
  logic             txdata_wr;
  logic             busy;
  logic [3:0]       status;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (reg_wdata[7:0]),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign intr_tx_full  = fifo_full;
  assign intr_tx_empty = fifo_empty;
  assign intr_tx_level = (fifo_count <= level);

  // A divisor below 2 would leave no room for the bit counter, so it holds off transmission.
  assign start_ok  = txen && !fifo_empty && (ctrl_div >= DIV_W'(2));
  assign bit_end   = (bit_cnt == '0);
  assign fifo_pop  = start_ok && ((state == IDLE) || ((state == STOP) && bit_end));
  assign txdata_wr = reg_we && (reg_addr == ADDR_TXDATA);
  assign fifo_push = txdata_wr && (!fifo_full || fifo_pop);
  assign busy      = (state != IDLE);

  assign status[STATUS_EMPTY]    = fifo_empty;
  assign status[STATUS_FULL]     = fifo_full;
  assign status[STATUS_BUSY]     = busy;
  assign status[STATUS_OVERFLOW] = overflow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_div <= '0;
      level    <= '0;
      txen     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (reg_we) begin
        case (reg_addr)
          ADDR_DIV:   ctrl_div <= reg_wdata[DIV_W-1:0];
          ADDR_LEVEL: level    <= reg_wdata[LVL_W-1:0];
          ADDR_TXEN:  txen     <= reg_wdata[0];
          ADDR_CLR:   if (reg_wdata[0]) overflow <= 1'b0;
          default:    ;
        endcase
      end
      if (txdata_wr && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_DIV:    rd_mux[DIV_W-1:0] = ctrl_div;
      ADDR_STATUS: rd_mux[3:0]       = status;
      ADDR_LEVEL:  rd_mux[LVL_W-1:0] = level;
      ADDR_TXEN:   rd_mux[0]         = txen;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rdata <= '0;
    end else if (reg_re) begin
      reg_rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_pop) begin
      shift_q <= fifo_rdata;
    end else if (bit_end && ((state == START) || (state == DATA))) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // A pop always launches a new frame, from IDLE or straight out of STOP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      intr_tx <= 1'b0;
      div_q   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      intr_tx <= (state == STOP) && bit_end;
      if (fifo_pop) begin
        state   <= START;
        tx_o    <= 1'b0;
        div_q   <= ctrl_div;
        bit_cnt <= ctrl_div - DIV_W'(1);
      end else begin
        case (state)
          IDLE: begin
            tx_o <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state   <= DATA;
              tx_o    <= shift_q[0];
              bit_idx <= '0;
              bit_cnt <= div_q - DIV_W'(1);
            end else begin
              bit_cnt <= bit_cnt - DIV_W'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              bit_cnt <= div_q - DIV_W'(1);
              if (bit_idx == 3'd7) begin
                state <= STOP;
                tx_o  <= 1'b1;
              end else begin
                tx_o    <= shift_q[0];
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              bit_cnt <= bit_cnt - DIV_W'(1);
            end
          end
          STOP: begin
            if (bit_end) begin
              state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt - DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: directed register and frame stimulus,
// with monitors decoding tx_o, register reads, flag snapshots and level edges.
module tb_uart_tx_engine;
  import uart_tx_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [11:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        tx_o;
  logic        intr_tx;
  logic        intr_tx_level;
  logic        intr_tx_full;
  logic        intr_tx_empty;

  always #5 clk_i = ~clk_i;

  uart_tx_engine #(
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .tx_o          (tx_o),
    .intr_tx       (intr_tx),
    .intr_tx_level (intr_tx_level),
    .intr_tx_full  (intr_tx_full),
    .intr_tx_empty (intr_tx_empty)
  );

  typedef struct {
    logic [7:0] b;
    logic       contig;
  } frame_t;

  typedef struct {
    logic [4:0] flags;
    int         intr;
  } snap_t;

  int          n_vec = 0;
  int          n_miss = 0;
  frame_t      frame_q[$];
  logic [31:0] rd_q[$];
  snap_t       snap_q[$];
  logic [1:0]  lvl_q[$];
  int          snap_req = 0;
  int          snap_done = 0;
  int          intr_cnt = 0;
  int          exp_intr = 0;
  int          cur_div = 4;
  logic        lvl_en = 1'b0;
  logic        lvl_prev = 1'b1;
  logic        rd_pend = 1'b0;
  logic        rst_seen = 1'b0;
  logic [31:0] rd_exp;
  snap_t       snap_exp;
  logic [1:0]  lvl_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: output seen with no expectation queued at %0t", name, $time);
  endtask

  always @(negedge rst_ni) rst_seen = 1'b1;

  // Register reads, flag snapshots, intr_tx pulse count and level edges.
  always @(negedge clk_i) begin
    if (intr_tx === 1'b1) intr_cnt++;
    if (rd_pend) begin
      if (rd_q.size() == 0) miss("reg_read");
      else begin
        rd_exp = rd_q.pop_front();
        chk("reg_read", reg_rdata, rd_exp);
      end
    end
    rd_pend = reg_re;
    if (snap_done < snap_req) begin
      snap_done++;
      if (snap_q.size() == 0) miss("snapshot");
      else begin
        snap_exp = snap_q.pop_front();
        chk("flags {tx,intr,full,empty,level}",
            32'({tx_o, intr_tx, intr_tx_full, intr_tx_empty, intr_tx_level}),
            32'(snap_exp.flags));
        chk("intr_tx pulse count", intr_cnt, snap_exp.intr);
      end
    end
    if (lvl_en && (intr_tx_level !== lvl_prev)) begin
      if (lvl_q.size() == 0) miss("level_edge");
      else begin
        lvl_exp = lvl_q.pop_front();
        chk("level_edge {level,intr}", 32'({intr_tx_level, intr_tx}), 32'(lvl_exp));
      end
    end
    lvl_prev = intr_tx_level;
  end

  // Serial decoder: samples first and last clock of each bit period.
  initial begin : frame_mon
    logic       contig;
    logic       glitch;
    logic       first;
    logic [9:0] bits;
    int         d;
    frame_t     e;
    contig = 1'b0;
    forever begin
      if (!contig) @(negedge clk_i);
      if (tx_o === 1'b0 && rst_ni === 1'b1) begin
        d        = cur_div;
        glitch   = 1'b0;
        rst_seen = 1'b0;
        bits     = '0;
        for (int k = 0; k < 10; k++) begin
          first = tx_o;
          repeat (d - 1) @(negedge clk_i);
          bits[k] = tx_o;
          if (first !== tx_o) glitch = 1'b1;
          if (k < 9) @(negedge clk_i);
        end
        @(negedge clk_i);
        if (!rst_seen) begin
          if (frame_q.size() == 0) miss("frame");
          else begin
            e = frame_q.pop_front();
            chk("frame {glitch,stop,data,start,contig}",
                {20'd0, glitch, bits, contig},
                {20'd0, 1'b0, 1'b1, e.b, 1'b0, e.contig});
            chk("intr_tx at stop end", 32'(intr_tx), 32'd1);
          end
        end
        contig = (tx_o === 1'b0);
      end else begin
        contig = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
  endtask

  task automatic wr_rd(input logic [11:0] a, input logic [31:0] d, input logic [31:0] e);
    rd_q.push_back(e);
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
  endtask

  task automatic snap(input logic [4:0] f);
    snap_t s;
    s.flags = f;
    s.intr  = exp_intr;
    snap_q.push_back(s);
    snap_req++;
  endtask

  task automatic exp_frame(input logic [7:0] b, input logic c);
    frame_t f;
    f.b = b;
    f.contig = c;
    frame_q.push_back(f);
  endtask

  initial begin
    // flags order: {tx, intr, full, empty, level}
    repeat (2) tick();
    snap(5'b10011);
    tick();
    rst_ni = 1'b1;
    tick();
    rd(ADDR_STATUS, 32'h1);
    rd(ADDR_DIV, 32'h0);
    rd(ADDR_LEVEL, 32'h0);
    rd(ADDR_TXEN, 32'h0);
    rd(12'h020, 32'h0);
    wr(ADDR_DIV, 32'h1234);
    rd(ADDR_DIV, 32'h1234);
    wr_rd(ADDR_DIV, 32'd4, 32'h1234);
    rd(ADDR_DIV, 32'd4);
    rd(ADDR_TXDATA, 32'h0);

    cur_div = 4;
    wr(ADDR_TXEN, 32'd1);
    exp_frame(8'h2B, 1'b0);
    wr(ADDR_TXDATA, 32'h2B);
    repeat (10) tick();
    rd(ADDR_STATUS, 32'h5);
    repeat (40) tick();
    exp_intr = 1;
    snap(5'b10011);

    wr(ADDR_DIV, 32'd2);
    cur_div = 2;
    exp_frame(8'h55, 1'b0);
    exp_frame(8'hAA, 1'b1);
    exp_frame(8'h00, 1'b1);
    wr(ADDR_TXDATA, 32'h55);
    wr(ADDR_TXDATA, 32'hAA);
    wr(ADDR_TXDATA, 32'h00);
    repeat (70) tick();
    exp_intr = 4;
    snap(5'b10011);

    wr(ADDR_TXEN, 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_frame(8'(8'h10 + i), (i != 0));
      wr(ADDR_TXDATA, 32'(8'h10 + i));
    end
    snap(5'b10100);
    rd(ADDR_STATUS, 32'hA);
    wr(ADDR_CLR, 32'd1);
    rd(ADDR_STATUS, 32'h2);
    wr(ADDR_TXEN, 32'd1);
    repeat (170) tick();
    exp_intr = 12;
    snap(5'b10011);
    rd(ADDR_STATUS, 32'h1);

    wr(ADDR_TXEN, 32'd0);
    wr(ADDR_LEVEL, 32'd2);
    wr(ADDR_DIV, 32'd3);
    cur_div = 3;
    lvl_q.push_back(2'b00);
    lvl_q.push_back(2'b11);
    lvl_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_frame(8'(8'h31 + i), (i != 0));
      wr(ADDR_TXDATA, 32'(8'h31 + i));
    end
    wr(ADDR_TXEN, 32'd1);
    repeat (130) tick();
    lvl_en = 1'b0;
    exp_intr = 16;
    snap(5'b10011);
    rd(ADDR_LEVEL, 32'd2);

    wr(ADDR_TXEN, 32'd0);
    wr(ADDR_DIV, 32'd4);
    cur_div = 4;
    wr(ADDR_LEVEL, 32'd1);
    exp_frame(8'h41, 1'b0);
    wr(ADDR_TXDATA, 32'h41);
    wr(ADDR_TXDATA, 32'h42);
    wr(ADDR_TXEN, 32'd1);
    repeat (14) tick();
    wr(ADDR_TXEN, 32'd0);
    repeat (45) tick();
    exp_intr = 17;
    snap(5'b10001);
    rd(ADDR_STATUS, 32'h0);

    wr(ADDR_TXEN, 32'd1);
    repeat (14) tick();
    rst_ni = 1'b0;
    snap(5'b10011);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (50) tick();
    snap(5'b10011);
    tick();
    rd(ADDR_DIV, 32'h0);
    rd(ADDR_STATUS, 32'h1);
    rd(ADDR_TXEN, 32'h0);
    rd(ADDR_LEVEL, 32'h0);
    repeat (3) tick();

    chk("frames pending", frame_q.size(), 0);
    chk("reads pending", rd_q.size(), 0);
    chk("snapshots pending", snap_q.size(), 0);
    chk("level edges pending", lvl_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
    $fatal(1);
  end

endmodule
